// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath and its job sequencer.
// Q5.10 operands, mode encodings and the sequencer state type.
package cordic_pkg;

  localparam int          FRAC_BITS = 10;
  localparam logic [15:0] ONE       = 16'h0400;

  localparam logic [1:0] SEL_MODE0 = 2'b00;
  localparam logic [1:0] SEL_MODE1 = 2'b01;
  localparam logic [1:0] SEL_MODE2 = 2'b10;
  localparam logic [1:0] SEL_RSVD  = 2'b11;

  localparam int DEFAULT_CORE_LATENCY = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_e;

  function automatic logic is_rsvd(input logic [1:0] sel);
    return sel == SEL_RSVD;
  endfunction

endpackage

// File: rtl/cordic_job_sequencer.sv
// Feeds operand jobs into the iterative CORDIC core, waits out its latency and
// returns the captured result with the job tag on a valid/ready stream.
//
// state | meaning
// IDLE  | core parked in reset, waiting for a job
// LOAD  | operands on core pins, core reset still high for one cycle
// RUN   | core iterating, counter runs down to the capture cycle
// HOLD  | result presented; one further job may be parked in the pending slot
module cordic_job_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH        = 15,
  parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             ext_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_x,
  input  logic [WIDTH:0]   in_y,
  input  logic [WIDTH:0]   in_z,
  input  logic [1:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH:0]   core_x,
  output logic [WIDTH:0]   core_y,
  output logic [WIDTH:0]   core_z,
  output logic [1:0]       core_sel,
  output logic             core_reset,
  input  logic [WIDTH:0]   core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int               CNT_W    = $clog2(CORE_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY - 1);

  seq_state_e       state;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] job_tag;

  logic             pend_valid;
  logic [WIDTH:0]   pend_x, pend_y, pend_z;
  logic [1:0]       pend_sel;
  logic [TAG_W-1:0] pend_tag;

  logic             in_fire, out_fire, nxt_avail;
  logic [WIDTH:0]   nxt_x, nxt_y, nxt_z;
  logic [1:0]       nxt_sel;
  logic [TAG_W-1:0] nxt_tag;

  // Ready comes from a register; the reset gate only keeps it low while reset is held.
  assign in_ready = rdy_q & ~ext_reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A parked job always takes priority over the port (in_ready is low while one is parked).
  always_comb begin
    nxt_avail = pend_valid | in_fire;
    nxt_x     = pend_valid ? pend_x   : in_x;
    nxt_y     = pend_valid ? pend_y   : in_y;
    nxt_z     = pend_valid ? pend_z   : in_z;
    nxt_sel   = pend_valid ? pend_sel : in_sel;
    nxt_tag   = pend_valid ? pend_tag : in_tag;
  end

  always_ff @(posedge clk) begin
    if (ext_reset) begin
      state      <= ST_IDLE;
      rdy_q      <= 1'b1;
      cnt        <= '0;
      job_tag    <= '0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      pend_sel   <= '0;
      pend_tag   <= '0;
      core_x     <= '0;
      core_y     <= '0;
      core_z     <= '0;
      core_sel   <= '0;
      core_reset <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (state == ST_HOLD && !out_fire) begin
            if (in_fire) begin
              pend_valid <= 1'b1;
              pend_x     <= in_x;
              pend_y     <= in_y;
              pend_z     <= in_z;
              pend_sel   <= in_sel;
              pend_tag   <= in_tag;
              rdy_q      <= 1'b0;
            end
          end else if (nxt_avail) begin
            pend_valid <= 1'b0;
            if (is_rsvd(nxt_sel)) begin
              // Reserved mode never touches the core; report it straight away.
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_data  <= '0;
              out_tag   <= nxt_tag;
              rdy_q     <= 1'b1;
            end else begin
              state     <= ST_LOAD;
              out_valid <= 1'b0;
              core_x    <= nxt_x;
              core_y    <= nxt_y;
              core_z    <= nxt_z;
              core_sel  <= nxt_sel;
              job_tag   <= nxt_tag;
              rdy_q     <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            rdy_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          cnt        <= CNT_LOAD;
          core_reset <= 1'b0;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == '0) begin
            out_data   <= core_result;
            out_err    <= 1'b0;
            out_tag    <= job_tag;
            out_valid  <= 1'b1;
            core_reset <= 1'b1;
            rdy_q      <= 1'b1;
            state      <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Bench for cordic_job_sequencer: stub core returning x+y after the core latency,
// directed scenarios plus a randomized run checked against an ordered job model.
module tb_cordic_job_sequencer;
  import cordic_pkg::*;

  localparam int WIDTH = 15;
  localparam int L     = 34;
  localparam int TAG_W = 4;
  localparam int LAT   = L + 2;

  logic             clk = 1'b0;
  logic             ext_reset;
  logic             in_valid, in_ready;
  logic [15:0]      in_x, in_y, in_z;
  logic [1:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic [15:0]      core_x, core_y, core_z;
  logic [1:0]       core_sel;
  logic             core_reset;
  logic [15:0]      core_result;
  logic             out_valid, out_ready;
  logic [15:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_job_sequencer #(.WIDTH(WIDTH), .CORE_LATENCY(L), .TAG_W(TAG_W)) dut (
    .clk(clk), .ext_reset(ext_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_sel(in_sel), .in_tag(in_tag),
    .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_sel(core_sel),
    .core_reset(core_reset), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  // Stub core: result is only meaningful once L cycles have elapsed out of reset.
  int sc = 0;
  always @(posedge clk) begin
    if (core_reset) sc <= 0;
    else if (sc < 1000) sc <= sc + 1;
  end
  assign core_result = (sc >= L - 1) ? 16'(core_x + core_y) : 16'hDEAD;

  function automatic logic [15:0] model_result(input logic [15:0] x, input logic [15:0] y,
                                               input logic [1:0] sel);
    return (sel == 2'b11) ? 16'h0000 : 16'(x + y);
  endfunction

  // Stream stability: payload frozen while valid and not ready.
  logic pv = 0, pr = 0, prst = 1, perr = 0, piv = 0, pir = 0;
  logic [15:0] pd = 0, pix = 0, piy = 0;
  logic [TAG_W-1:0] pt = 0, pit = 0;
  always @(negedge clk) begin
    if (pv && !pr && !prst && !ext_reset) begin
      checks++;
      if (!(out_valid && out_data == pd && out_tag == pt && out_err == perr)) begin
        errors++;
        $display("FAIL out_stable: got v=%0b d=%h t=%0d e=%0b exp v=1 d=%h t=%0d e=%0b",
                 out_valid, out_data, out_tag, out_err, pd, pt, perr);
      end
    end
    if (piv && !pir && !prst && !ext_reset) begin
      checks++;
      if (!(in_valid && in_x == pix && in_y == piy && in_tag == pit)) begin
        errors++;
        $display("FAIL in_stable: got v=%0b x=%h y=%h t=%0d exp v=1 x=%h y=%h t=%0d",
                 in_valid, in_x, in_y, in_tag, pix, piy, pit);
      end
    end
    pv = out_valid; pr = out_ready; prst = ext_reset; perr = out_err; pd = out_data; pt = out_tag;
    piv = in_valid; pir = in_ready; pix = in_x; piy = in_y; pit = in_tag;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input logic [1:0] sel, input logic [TAG_W-1:0] tag);
    in_x = x; in_y = y; in_z = z; in_sel = sel; in_tag = tag; in_valid = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    ext_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = 0; in_y = 0; in_z = 0; in_sel = 0; in_tag = 0;
    repeat (3) step();
    checks++;
    if (!(in_ready == 0 && out_valid == 0 && out_data == 0 && out_tag == 0 && out_err == 0 &&
          core_x == 0 && core_y == 0 && core_z == 0 && core_sel == 0 && core_reset == 1)) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b ov=%0b d=%h t=%0d e=%0b cx=%h cs=%0d cr=%0b exp rdy=0 ov=0 d=0 t=0 e=0 cx=0 cs=0 cr=1",
               in_ready, out_valid, out_data, out_tag, out_err, core_x, core_sel, core_reset);
    end
    ext_reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_single();
    int n;
    drive_job(16'h0300, 16'h0100, 16'h01C5, SEL_MODE0, 4'd3);
    step();
    in_valid = 1'b0;
    checks++;
    if (!(core_reset == 1 && core_x == 16'h0300 && core_y == 16'h0100 && core_z == 16'h01C5 && core_sel == 0)) begin
      errors++;
      $display("FAIL single_load: got cr=%0b x=%h y=%h z=%h s=%0d exp cr=1 x=0300 y=0100 z=01c5 s=0",
               core_reset, core_x, core_y, core_z, core_sel);
    end
    step();
    checks++;
    if (!(core_reset == 0 && out_valid == 0 && in_ready == 0)) begin
      errors++;
      $display("FAIL single_run: got cr=%0b ov=%0b rdy=%0b exp cr=0 ov=0 rdy=0", core_reset, out_valid, in_ready);
    end
    wait_valid(100, n);
    checks++;
    if (2 + n != LAT) begin
      errors++; $display("FAIL single_latency: got %0d exp %0d", 2 + n, LAT);
    end
    checks++;
    if (!(out_valid && out_data == model_result(16'h0300, 16'h0100, SEL_MODE0) && out_tag == 3 && out_err == 0)) begin
      errors++;
      $display("FAIL single_result: got v=%0b d=%h t=%0d e=%0b exp v=1 d=0400 t=3 e=0", out_valid, out_data, out_tag, out_err);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (!(out_valid == 0 && in_ready == 1)) begin
      errors++; $display("FAIL single_done: got ov=%0b rdy=%0b exp ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reserved();
    int bad = 0;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), SEL_RSVD, 4'd5);
    step();
    in_valid = 1'b0;
    checks++;
    if (!(out_valid == 1 && out_err == 1 && out_data == 0 && out_tag == 5 && core_reset == 1)) begin
      errors++;
      $display("FAIL rsvd_result: got v=%0b e=%0b d=%h t=%0d cr=%0b exp v=1 e=1 d=0 t=5 cr=1",
               out_valid, out_err, out_data, out_tag, core_reset);
    end
    repeat (5) begin
      step();
      if (core_reset != 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rsvd_core_parked: got %0d cycles with core_reset low exp 0", bad);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rsvd_done: got ov=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    logic [15:0] x1, y1, exp1;
    x1 = 16'($urandom); y1 = 16'($urandom);
    exp1 = model_result(x1, y1, SEL_MODE1);
    drive_job(x1, y1, 16'($urandom), SEL_MODE1, 4'd7);
    step();
    in_valid = 1'b0;
    wait_valid(100, n);
    checks++;
    if (1 + n != LAT) begin
      errors++; $display("FAIL bp_latency1: got %0d exp %0d", 1 + n, LAT);
    end
    repeat (50) begin
      step();
      if (!(out_valid && out_data == exp1 && out_tag == 7)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: got %0d cycles off exp 0 (d=%h)", bad, exp1);
    end
    drive_job(16'h0080, 16'h001D, 16'($urandom), SEL_MODE2, 4'd8);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_hold: got %0b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (!(in_ready == 0 && core_reset == 1 && out_data == exp1 && out_tag == 7)) begin
      errors++;
      $display("FAIL bp_pending: got rdy=%0b cr=%0b d=%h t=%0d exp rdy=0 cr=1 d=%h t=7",
               in_ready, core_reset, out_data, out_tag, exp1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (!(out_valid == 0 && core_reset == 1 && core_x == 16'h0080)) begin
      errors++; $display("FAIL bp_load2: got ov=%0b cr=%0b cx=%h exp ov=0 cr=1 cx=0080", out_valid, core_reset, core_x);
    end
    wait_valid(100, n);
    checks++;
    if (!(1 + n == LAT && out_data == 16'h009D && out_tag == 8 && out_err == 0)) begin
      errors++;
      $display("FAIL bp_result2: got lat=%0d d=%h t=%0d e=%0b exp lat=%0d d=009d t=8 e=0", 1 + n, out_data, out_tag, out_err, LAT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] jx[4], jy[4];
    logic [1:0]  js[4];
    int res_c[4], res_t[4];
    logic [15:0] res_d[4];
    int idx = 0, nres = 0;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      jx[i] = 16'($urandom); jy[i] = 16'($urandom); js[i] = 2'($urandom_range(0, 2));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 400 && nres < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_x = jx[idx]; in_y = jy[idx]; in_z = 16'(idx); in_sel = js[idx]; in_tag = TAG_W'(idx);
      end
      #0;
      acc = in_valid && in_ready;
      if (out_valid) begin
        res_c[nres] = c; res_t[nres] = int'(out_tag); res_d[nres] = out_data;
        nres++;
      end
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nres != 4) begin
      errors++; $display("FAIL b2b_count: got %0d exp 4", nres);
    end
    for (int i = 0; i < nres; i++) begin
      checks++;
      if (!(res_t[i] == i && res_d[i] == model_result(jx[i], jy[i], js[i]) &&
            (i == 0 || res_c[i] - res_c[i-1] == LAT))) begin
        errors++;
        $display("FAIL b2b_result%0d: got t=%0d d=%h gap=%0d exp t=%0d d=%h gap=%0d", i, res_t[i], res_d[i],
                 (i == 0) ? 0 : res_c[i] - res_c[i-1], i, model_result(jx[i], jy[i], js[i]), (i == 0) ? 0 : LAT);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    drive_job(16'h0123, 16'h0042, 16'h0001, SEL_MODE0, 4'd9);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    ext_reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready_low: got %0b exp 0", in_ready);
    end
    step();
    ext_reset = 1'b0;
    #1;
    checks++;
    if (!(in_ready == 1 && core_reset == 1 && out_valid == 0)) begin
      errors++; $display("FAIL rst_after: got rdy=%0b cr=%0b ov=%0b exp rdy=1 cr=1 ov=0", in_ready, core_reset, out_valid);
    end
    out_ready = 1'b1;
    repeat (60) begin
      step();
      if (out_valid || !core_reset) bad++;
    end
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_no_output: got %0d bad cycles exp 0", bad);
    end
  endtask

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int jobs_acc = 0, jobs_out = 0, c = 0;
    logic acc, fire;
    in_valid = 1'b0;
    while (jobs_out < 200 && c < 30000) begin
      if (!in_valid && jobs_acc < 200 && $urandom_range(0, 1) == 1)
        drive_job(16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), TAG_W'(jobs_acc));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got tag=%0d with no job outstanding", out_tag);
        end else begin
          e = q.pop_front();
          if (!(out_data == e.data && out_tag == e.tag && out_err == e.err)) begin
            errors++;
            $display("FAIL rand_result: got d=%h t=%0d e=%0b exp d=%h t=%0d e=%0b",
                     out_data, out_tag, out_err, e.data, e.tag, e.err);
          end
        end
        jobs_out++;
      end
      if (acc) begin
        e.data = model_result(in_x, in_y, in_sel);
        e.tag  = in_tag;
        e.err  = (in_sel == 2'b11);
        q.push_back(e);
      end
      step();
      c++;
      if (acc) begin
        in_valid = 1'b0;
        jobs_acc++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (!(jobs_out == 200 && jobs_acc == 200 && q.size() == 0)) begin
      errors++;
      $display("FAIL rand_complete: got out=%0d acc=%0d left=%0d cycles=%0d exp out=200 acc=200 left=0",
               jobs_out, jobs_acc, q.size(), c);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cordic_job_sequencer.md
Name: cordic_job_sequencer

Overview:
- Initiator-side controller for the iterative CORDIC core (recon_top_level).
- Accepts operand jobs (X, Y, Z, mode select) on a valid/ready stream and loads each one into the core by pulsing the core reset with operands stable.
- Waits the core's fixed iteration latency, captures the core result and returns it on a valid/ready output stream with a job tag.
- Sits between the NN layer scheduler and the CORDIC datapath, replacing hand-timed reset/operand driving.

Parameters:
- WIDTH, 15, MSB index of operand/result words (data width WIDTH+1 = 16, Q5.10 fixed point)
- CORE_LATENCY, 34, clock cycles from core reset deassertion to valid core result
- TAG_W, 4, width of job tag

Ports:
- clk  in  1  system clock
- ext_reset  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  sequencer can accept job
- in_x  in  WIDTH+1  X operand
- in_y  in  WIDTH+1  Y operand
- in_z  in  WIDTH+1  Z operand (angle)
- in_sel  in  2  CORDIC mode; 2'b11 reserved
- in_tag  in  TAG_W  job identifier
- core_x, core_y, core_z  out  WIDTH+1 each  operands to core
- core_sel  out  2  mode to core
- core_reset  out  1  core load/reset, active-high
- core_result  in  WIDTH+1  core output z
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH+1  captured result
- out_tag  out  TAG_W  tag of the job
- out_err  out  1  job had reserved sel; out_data = 0

Behaviour:
- Reset (ext_reset=1 at a clock edge):
  - state=IDLE; in_ready=0 during reset and 1 in the cycle after.
  - out_valid=0, out_data=0, out_tag=0, out_err=0.
  - core_x/y/z=0, core_sel=0, core_reset=1 (held while ext_reset high).
- Reset mid-job: aborts immediately, no output produced, in-flight job discarded.
- States: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - in_ready=1 and core_reset=1 (core parked).
  - Accept on in_valid&in_ready at edge T: latch x, y, z, sel, tag.
  - If sel!=3: go to LOAD.
  - If sel==3: go straight to HOLD with out_err=1, out_data=0, out_tag=tag; core is not started.
- LOAD (cycle T+1):
  - core_x/y/z/sel driven from latches; core_reset=1.
  - Counter loaded with CORE_LATENCY-1; next state RUN.
- RUN (cycles T+2 .. T+1+CORE_LATENCY):
  - core_reset=0; operands held stable.
  - Counter decrements each cycle.
  - At the edge ending the cycle where counter==0: capture core_result into out_data, out_err=0, out_tag=tag; go to HOLD.
- HOLD:
  - out_valid=1 from cycle T+2+CORE_LATENCY, i.e. accept-to-valid latency = CORE_LATENCY+2 cycles.
  - out_data, out_tag and out_err are stable until out_valid&out_ready.
  - core_reset=1 (core parked); in_ready=1 so the next job can be latched.
  - Handshake outcome at the same edge:
    - out_valid&out_ready and a new job accepted together: next state LOAD.
    - out_valid&out_ready with no new job: IDLE.
    - New job accepted but out_ready=0: store it in a one-entry pending register, drop in_ready to 0 and stay in HOLD; on output handshake go to LOAD with the pending job.
- Back-to-back jobs: throughput is one job per CORE_LATENCY+2 cycles when out_ready is held 1.
- in_ready is never combinationally dependent on in_valid.
- Payload on both streams must not change while valid is high and ready is low; the bench asserts this.
- Operands pass through unmodified; no arithmetic in this block other than the counter.
- Counter width: $clog2(CORE_LATENCY)+1.

Decomposition:
- Shared package cordic_pkg:
  - Q5.10 format constants: FRAC_BITS=10, ONE=16'h0400.
  - Mode encodings: SEL_MODE0=2'b00, SEL_MODE1=2'b01, SEL_MODE2=2'b10, SEL_RSVD=2'b11.
  - Sequencer state enum.
  - Default CORE_LATENCY.
- No sub-module required. The pending-job register is inline.
- Top-level integration instantiates recon_top_level next to this block.

Test Plan:
- Single job, stub core returning x+y after CORE_LATENCY: x=16'h0300, y=16'h0100, z=16'h01C5, sel=00, tag=3 → core_reset high at T+1 and low at T+2; out_valid at T+36; out_data=16'h0400, out_tag=3.
- Reserved mode: sel=11, tag=5 → out_valid at T+1, out_err=1, out_data=0; core_reset never deasserts.
- Back-pressure: out_ready=0 for 50 cycles after valid, then second job x=16'h0080, y=16'h001D offered → in_ready drops after the pending accept; outputs stable; after out_ready=1, second result 16'h009D arrives 36 cycles later.
- Back-to-back: 4 jobs, out_ready=1 throughout → results 36 cycles apart; tags 0,1,2,3 in order.
- Reset mid-RUN: ext_reset=1 at T+10 for 1 cycle → out_valid stays 0; core_reset=1; in_ready=1 the cycle after reset.
- Stability checker: random out_ready and in_valid over 200 jobs → no payload change while stalled, no lost or duplicated tags.
